// File: rtl/game_pkg.sv
// Shared types and helpers for the game-control blocks: FSM states, BCD widths
// and the binary-to-two-digit-BCD conversion.
package game_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SEC_W   = 7;
    localparam int unsigned MAX_SEC = 99;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    // Callers clamp to 0..99 first so tens stays a legal digit.
    function automatic bcd2_t bin_to_bcd2(input logic [SEC_W-1:0] v);
        bcd2_t r;
        r.tens = BCD_W'(v / SEC_W'(10));
        r.ones = BCD_W'(v % SEC_W'(10));
        return r;
    endfunction

endpackage

// File: rtl/edge_tick.sv
// Rising-edge detector for a clk-domain level; history resets high so a level
// already high at reset release is not mistaken for an edge.
module edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse,
    output logic rise_c
);

    logic r_q;
    logic r_qq;

    assign rise_c = r_q & ~r_qq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= 1'b1;
            r_qq  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            r_q   <= in;
            r_qq  <= r_q;
            pulse <= rise_c;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Start/pause-able seconds countdown driven by slow_clk rising edges, with
// two-digit BCD display outputs and timeout/expired flags for game control.
module countdown_timer
    import game_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter int unsigned MAX_SEC       = game_pkg::MAX_SEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             pause,
    input  logic [SEC_W-1:0] load_sec,
    output logic             tick,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             expired,
    output logic             timeout
);

    localparam int unsigned      SUB_W    = 8;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] LOAD_MAX = SEC_W'(MAX_SEC);

    state_t           r_state;
    state_t           w_state_nxt;
    bcd2_t            r_digits;
    bcd2_t            w_digits_nxt;
    bcd2_t            w_dec;
    bcd2_t            w_load_bcd;
    logic [SEC_W-1:0] w_load;
    logic [SUB_W-1:0] r_subcnt;
    logic [SUB_W-1:0] w_sub_nxt;
    logic             w_rise;
    logic             w_to_done;
    logic             w_running_nxt;
    logic             w_expired_nxt;
    logic             w_timeout_nxt;

    edge_tick u_edge_tick (
        .clk    (clk),
        .rst    (rst),
        .in     (slow_clk),
        .pulse  (tick),
        .rise_c (w_rise)
    );

    assign w_load     = (load_sec > LOAD_MAX) ? LOAD_MAX : load_sec;
    assign w_load_bcd = bin_to_bcd2(w_load);
    assign sec_tens   = r_digits.tens;
    assign sec_ones   = r_digits.ones;

    // BCD borrow; only applied in RUN, where the value is never 00.
    always_comb begin
        w_dec = r_digits;
        if (r_digits.ones == '0) begin
            w_dec.ones = BCD_W'(9);
            w_dec.tens = BCD_W'(r_digits.tens - BCD_W'(1));
        end else begin
            w_dec.ones = BCD_W'(r_digits.ones - BCD_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start outranks everything; a tick is counted before a coincident pause.
    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_sub_nxt    = r_subcnt;
        w_to_done    = 1'b0;
        if (start) begin
            w_digits_nxt = w_load_bcd;
            w_sub_nxt    = '0;
            if (w_load == '0) begin
                w_state_nxt = DONE;
                w_to_done   = 1'b1;
            end else begin
                w_state_nxt = RUN;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (w_rise) begin
                        if (r_subcnt == SUB_LAST) begin
                            w_sub_nxt    = '0;
                            w_digits_nxt = w_dec;
                            if (w_dec == '0) begin
                                w_state_nxt = DONE;
                                w_to_done   = 1'b1;
                            end
                        end else begin
                            w_sub_nxt = SUB_W'(r_subcnt + SUB_W'(1));
                        end
                    end
                    if (pause && !w_to_done) begin
                        w_state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_running_nxt = (w_state_nxt == RUN);
        w_expired_nxt = (w_state_nxt == DONE);
        w_timeout_nxt = w_to_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_subcnt <= '0;
            running  <= 1'b0;
            expired  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            r_digits <= w_digits_nxt;
            r_subcnt <= w_sub_nxt;
            running  <= w_running_nxt;
            expired  <= w_expired_nxt;
            timeout  <= w_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// start/pause/reset traffic, all checked against a seconds-level reference model.
module tb_countdown_timer;

    localparam int TPS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       slow_clk = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] load_sec = '0;
    logic       tick;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       expired;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining seconds as a plain integer.
    bit m_q = 1, m_qq = 1, m_tick = 0;
    int m_rem = 0, m_sub = 0;
    bit m_run = 0, m_paused = 0, m_done = 0, m_timeout = 0;

    bit free_run = 0;
    int phase = 0;

    countdown_timer #(.TICKS_PER_SEC(TPS), .MAX_SEC(99)) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .pause    (pause),
        .load_sec (load_sec),
        .tick     (tick),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .expired  (expired),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    wire [11:0] dut_vec = {tick, running, expired, timeout, sec_tens, sec_ones};

    function automatic logic [11:0] exp_vec();
        return {m_tick, m_run, m_done, m_timeout, 4'(m_rem / 10), 4'(m_rem % 10)};
    endfunction

    task automatic model_edge();
        bit rise;
        rise = m_q & ~m_qq;
        if (rst) begin
            m_q = 1; m_qq = 1; m_tick = 0; m_rem = 0; m_sub = 0;
            m_run = 0; m_paused = 0; m_done = 0; m_timeout = 0;
        end else begin
            m_qq = m_q;
            m_q = slow_clk;
            m_tick = rise;
            m_timeout = 0;
            if (start) begin
                m_rem = (load_sec > 7'd99) ? 99 : int'(load_sec);
                m_sub = 0;
                m_paused = 0;
                m_run = (m_rem != 0);
                m_done = (m_rem == 0);
                m_timeout = m_done;
            end else if (m_run) begin
                if (rise) begin
                    if (m_sub == TPS - 1) begin
                        m_sub = 0;
                        m_rem--;
                        if (m_rem == 0) begin
                            m_run = 0; m_done = 1; m_timeout = 1;
                        end
                    end else begin
                        m_sub++;
                    end
                end
                if (pause && m_run) begin
                    m_run = 0; m_paused = 1;
                end
            end else if (m_paused && pause) begin
                m_paused = 0; m_run = 1;
            end
        end
    endtask

    // One clk cycle: model follows the edge, outputs settle, slow_clk advances.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (free_run) begin
            phase++;
            if (phase == 4) begin
                phase = 0;
                slow_clk = ~slow_clk;
            end
        end
    endtask

    task automatic pulse_start(input logic [6:0] val);
        load_sec = val;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        for (int i = 0; i < n * 8 + 16 && seen < n; i++) begin
            step();
            if (m_tick) seen++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        slow_clk = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (dut_vec !== 12'h000) begin
                n_errors++;
                $display("FAIL reset_idle cyc%0d: got %h exp 000", i, dut_vec);
            end
        end
        free_run = 1;
        phase = 0;
    endtask

    task automatic test_countdown();
        int n_to = 0;
        pulse_start(7'd3);
        n_checks++;
        if ({running, sec_tens, sec_ones} !== {1'b1, 4'd0, 4'd3}) begin
            n_errors++;
            $display("FAIL countdown_load: got r=%b %0d/%0d exp r=1 0/3", running, sec_tens, sec_ones);
        end
        for (int i = 0; i < 70; i++) begin
            step();
            if (timeout) n_to++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL countdown cyc%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if ({n_to, expired, running, sec_tens, sec_ones} !== {32'd1, 1'b1, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL countdown_end: got to=%0d exp=%b run=%b %0d/%0d exp to=1 1 0 0/0",
                     n_to, expired, running, sec_tens, sec_ones);
        end
    endtask

    task automatic test_borrow();
        pulse_start(7'd10);
        run_ticks(2);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h09) begin
            n_errors++;
            $display("FAIL borrow_09: got %0d/%0d exp 0/9", sec_tens, sec_ones);
        end
        run_ticks(2);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h08) begin
            n_errors++;
            $display("FAIL borrow_08: got %0d/%0d exp 0/8", sec_tens, sec_ones);
        end
    endtask

    task automatic test_clamp_zero();
        pulse_start(7'd120);
        n_checks++;
        if ({sec_tens, sec_ones, running} !== {8'h99, 1'b1}) begin
            n_errors++;
            $display("FAIL clamp_99: got %0d/%0d r=%b exp 9/9 r=1", sec_tens, sec_ones, running);
        end
        pulse_start(7'd0);
        n_checks++;
        if ({expired, timeout, running, sec_tens, sec_ones} !== {3'b110, 8'h00}) begin
            n_errors++;
            $display("FAIL zero_load: got e=%b t=%b r=%b %0d/%0d exp 1 1 0 0/0",
                     expired, timeout, running, sec_tens, sec_ones);
        end
        step();
        n_checks++;
        if ({expired, timeout} !== 2'b10) begin
            n_errors++;
            $display("FAIL zero_one_shot: got e=%b t=%b exp e=1 t=0", expired, timeout);
        end
    endtask

    task automatic test_pause();
        pulse_start(7'd5);
        run_ticks(1);
        pulse_pause();
        run_ticks(10);
        n_checks++;
        if ({running, sec_tens, sec_ones} !== {1'b0, 8'h05}) begin
            n_errors++;
            $display("FAIL pause_hold: got r=%b %0d/%0d exp r=0 0/5", running, sec_tens, sec_ones);
        end
        pulse_pause();
        run_ticks(1);
        n_checks++;
        if ({running, sec_tens, sec_ones} !== {1'b1, 8'h04}) begin
            n_errors++;
            $display("FAIL pause_resume: got r=%b %0d/%0d exp r=1 0/4", running, sec_tens, sec_ones);
        end
    endtask

    task automatic test_priority();
        pulse_start(7'd3);
        run_ticks(2);
        for (int i = 0; i < 16 && !(m_q && !m_qq); i++) step();
        load_sec = 7'd7;
        start = 1'b1;
        pause = 1'b1;
        step();
        start = 1'b0;
        pause = 1'b0;
        n_checks++;
        if ({tick, running, sec_tens, sec_ones} !== {2'b11, 8'h07}) begin
            n_errors++;
            $display("FAIL priority_restart: got tick=%b r=%b %0d/%0d exp 1 1 0/7",
                     tick, running, sec_tens, sec_ones);
        end
        run_ticks(1);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h07) begin
            n_errors++;
            $display("FAIL priority_sub0: got %0d/%0d exp 0/7", sec_tens, sec_ones);
        end
        run_ticks(1);
        n_checks++;
        if ({sec_tens, sec_ones} !== 8'h06) begin
            n_errors++;
            $display("FAIL priority_dec: got %0d/%0d exp 0/6", sec_tens, sec_ones);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(7'd1);
        run_ticks(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (dut_vec !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_mid: got %h exp 000", dut_vec);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec() || timeout !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_mid cyc%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 499) == 0);
            load_sec = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(0, 4));
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL random cyc%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        start = 1'b0;
        pause = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_clamp_zero();
        test_pause();
        test_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
